// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Request/response handshake bundle between requesters and the
//            shared ALU arbiter.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [3:0]  ReqControl;
    logic [63:0] ReqSrcA;
    logic [63:0] ReqSrcB;
    logic [1:0]  RspValid;
    logic [1:0]  RspReady;
    logic [31:0] RspResult;
    logic [3:0]  RspFlags;

    // Requester side
    modport master (
        output ReqValid, ReqControl, ReqSrcA, ReqSrcB, RspReady,
        input  ReqReady, RspValid, RspResult, RspFlags
    );

    // Arbiter side
    modport slave (
        input  ReqValid, ReqControl, ReqSrcA, ReqSrcB, RspReady,
        output ReqReady, RspValid, RspResult, RspFlags
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with embedded alu)
// Purpose  : Two-requester arbiter sharing one 32-bit ALU, one op in flight.
// Revision : 1.0
// ============================================================================
module alu (
    input  wire logic [31:0] SrcA,
    input  wire logic [31:0] SrcB,
    input  wire logic [1:0]  ALUControl,
    output logic      [31:0] ALUResult,
    output logic      [3:0]  ALUFlags
);
    logic [31:0] b_mux;
    logic [32:0] sum;

    always_comb begin
        b_mux = ALUControl[0] ? ~SrcB : SrcB;
        sum   = {1'b0, SrcA} + {1'b0, b_mux} + {32'b0, ALUControl[0]};
        case (ALUControl)
            2'b00, 2'b01: ALUResult = sum[31:0];
            2'b10:        ALUResult = SrcA & SrcB;
            default:      ALUResult = SrcA | SrcB;
        endcase
        // Carry and overflow are only meaningful for the adder ops
        ALUFlags[3] = ALUResult[31];
        ALUFlags[2] = (ALUResult == 32'd0);
        ALUFlags[1] = ~ALUControl[1] & sum[32];
        ALUFlags[0] = ~ALUControl[1] & ~(SrcA[31] ^ SrcB[31] ^ ALUControl[0])
                      & (SrcA[31] ^ sum[31]);
    end
endmodule

module alu_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        winner_q, winner_d;
    logic        last_q, last_d;
    logic [1:0]  op_ctrl_q, op_ctrl_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;

    logic        pick;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    alu u_alu (
        .SrcA       (op_a_q),
        .SrcB       (op_b_q),
        .ALUControl (op_ctrl_q),
        .ALUResult  (alu_result),
        .ALUFlags   (alu_flags)
    );

    always_comb begin
        // Winner when both are valid: requester 0 in fixed mode, else the one not last served
        if (PRIORITY_MODE == 1) begin
            pick = ~bus.ReqValid[0];
        end else if (bus.ReqValid == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = bus.ReqValid[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_d       = last_q;
        op_ctrl_d    = op_ctrl_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.ReqValid != 2'b00) begin
                    req_ready = pick ? 2'b10 : 2'b01;
                    winner_d  = pick;
                    op_ctrl_d = pick ? bus.ReqControl[3:2] : bus.ReqControl[1:0];
                    op_a_d    = pick ? bus.ReqSrcA[63:32]  : bus.ReqSrcA[31:0];
                    op_b_d    = pick ? bus.ReqSrcB[63:32]  : bus.ReqSrcB[31:0];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid = winner_q ? 2'b10 : 2'b01;
                if (bus.RspReady[winner_q]) begin
                    last_d  = winner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            last_q       <= 1'b1;
            op_ctrl_q    <= 2'b00;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_q       <= last_d;
            op_ctrl_q    <= op_ctrl_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.ReqReady  = req_ready;
    assign bus.RspValid  = rsp_valid;
    assign bus.RspResult = rsp_result_q;
    assign bus.RspFlags  = rsp_flags_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for round-robin and fixed-priority
//            arbiter instances.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if bus_a ();
    alu_arbiter_if bus_b ();

    alu_arbiter #(.PRIORITY_MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    alu_arbiter #(.PRIORITY_MODE(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_a.ReqValid = 2'b00; bus_a.ReqControl = 4'h0; bus_a.ReqSrcA = 64'd0;
        bus_a.ReqSrcB = 64'd0;  bus_a.RspReady = 2'b00;
        bus_b.ReqValid = 2'b00; bus_b.ReqControl = 4'h0; bus_b.ReqSrcA = 64'd0;
        bus_b.ReqSrcB = 64'd0;  bus_b.RspReady = 2'b00;

        // Reset then idle
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_req_ready", {30'd0, bus_a.ReqReady}, 32'd0);
            chk("idle_rsp_valid", {30'd0, bus_a.RspValid}, 32'd0);
            chk("idle_result",    bus_a.RspResult, 32'd0);
            chk("idle_flags",     {28'd0, bus_a.RspFlags}, 32'd0);
            tick();
        end

        // Single SUB 1-1
        bus_a.ReqValid = 2'b01; bus_a.ReqControl = 4'b0001;
        bus_a.ReqSrcA = {32'd0, 32'd1}; bus_a.ReqSrcB = {32'd0, 32'd1};
        #1 chk("sub_accept", {30'd0, bus_a.ReqReady}, 32'h1);
        tick();
        bus_a.ReqValid = 2'b00;
        #1 chk("sub_exec_ready", {30'd0, bus_a.ReqReady}, 32'd0);
        chk("sub_exec_valid", {30'd0, bus_a.RspValid}, 32'd0);
        tick();
        bus_a.RspReady = 2'b01;
        #1 chk("sub_rsp_valid", {30'd0, bus_a.RspValid}, 32'h1);
        chk("sub_result", bus_a.RspResult, 32'd0);
        chk("sub_flags", {28'd0, bus_a.RspFlags}, 32'h6);
        tick();
        #1 chk("sub_done_valid", {30'd0, bus_a.RspValid}, 32'd0);

        // Round-robin tie starting from reset state
        reset = 1'b1; tick(); reset = 1'b0;
        bus_a.ReqValid = 2'b11; bus_a.ReqControl = 4'b1100;
        bus_a.ReqSrcA = {32'd0, 32'd1}; bus_a.ReqSrcB = {32'd1, 32'd0};
        bus_a.RspReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", {30'd0, bus_a.ReqReady}, (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            #1 chk("rr_exec_ready", {30'd0, bus_a.ReqReady}, 32'd0);
            tick();
            #1 chk("rr_rsp_valid", {30'd0, bus_a.RspValid}, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_result", bus_a.RspResult, 32'd1);
            chk("rr_flags", {28'd0, bus_a.RspFlags}, 32'd0);
            tick();
        end
        bus_a.ReqValid = 2'b00; bus_a.RspReady = 2'b00;

        // Fixed priority: requester 0 always wins
        bus_b.ReqValid = 2'b11; bus_b.ReqControl = 4'b1100;
        bus_b.ReqSrcA = {32'd0, 32'd1}; bus_b.ReqSrcB = {32'd1, 32'd0};
        bus_b.RspReady = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 chk("fp_grant", {30'd0, bus_b.ReqReady}, 32'h1);
            tick(); tick();
            #1 chk("fp_rsp_valid", {30'd0, bus_b.RspValid}, 32'h1);
            tick();
        end
        bus_b.ReqValid = 2'b00; bus_b.RspReady = 2'b00;

        // Response backpressure
        reset = 1'b1; tick(); reset = 1'b0;
        bus_a.ReqValid = 2'b10; bus_a.ReqControl = 4'b0100;
        bus_a.ReqSrcA = {32'd1, 32'd5}; bus_a.ReqSrcB = {32'd2, 32'd7};
        bus_a.RspReady = 2'b00;
        #1 chk("bp_grant1", {30'd0, bus_a.ReqReady}, 32'h2);
        tick();
        bus_a.ReqValid = 2'b01;
        #1 chk("bp_exec_ready", {30'd0, bus_a.ReqReady}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_a.RspReady = (i == 4) ? 2'b01 : 2'b00;
            #1 chk("bp_hold_valid", {30'd0, bus_a.RspValid}, 32'h2);
            chk("bp_hold_result", bus_a.RspResult, 32'hFFFF_FFFF);
            chk("bp_hold_flags", {28'd0, bus_a.RspFlags}, 32'h8);
            chk("bp_hold_ready", {30'd0, bus_a.ReqReady}, 32'd0);
            tick();
        end
        bus_a.RspReady = 2'b10;
        #1 chk("bp_release_valid", {30'd0, bus_a.RspValid}, 32'h2);
        tick();
        bus_a.RspReady = 2'b11;
        #1 chk("bp_grant0", {30'd0, bus_a.ReqReady}, 32'h1);
        tick();
        bus_a.ReqValid = 2'b00;
        tick();
        #1 chk("bp_add_valid", {30'd0, bus_a.RspValid}, 32'h1);
        chk("bp_add_result", bus_a.RspResult, 32'd12);
        chk("bp_add_flags", {28'd0, bus_a.RspFlags}, 32'd0);
        tick();

        // Reset mid-operation (last-granted is 0 before reset)
        bus_a.ReqValid = 2'b10; bus_a.RspReady = 2'b11;
        #1 chk("mid_grant1", {30'd0, bus_a.ReqReady}, 32'h2);
        tick();
        bus_a.ReqValid = 2'b00; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mid_no_rsp", {30'd0, bus_a.RspValid}, 32'd0);
            tick();
        end
        bus_a.ReqValid = 2'b11;
        #1 chk("mid_tie_grant", {30'd0, bus_a.ReqReady}, 32'h1);
        tick();
        bus_a.ReqValid = 2'b00;
        tick();
        #1 chk("mid_rsp_valid", {30'd0, bus_a.RspValid}, 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit `alu` datapath between two requesters (e.g. the core's execute path and a debug/self-test port) with valid/ready handshakes on both request and response sides. It arbitrates between pending requests, drives the selected operands and `ALUControl` into an internal `alu` instance, registers `ALUResult`/`ALUFlags`, and returns them to the granted requester. One operation is in flight at a time; the ALU itself is unchanged.

## Interface
- `PRIORITY_MODE`, default 0: 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins ties.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `ReqValid` input [1:0]: bit i = requester i has an operation pending.
- `ReqReady` output [1:0]: bit i = request i accepted this cycle (at most one bit set).
- `ReqControl` input [3:0]: bits [2i+1:2i] = ALUControl of requester i (00 ADD, 01 SUB, 10 AND, 11 ORR).
- `ReqSrcA` input [63:0]: bits [32i+31:32i] = SrcA of requester i.
- `ReqSrcB` input [63:0]: bits [32i+31:32i] = SrcB of requester i.
- `RspValid` output [1:0]: bit i = result for requester i available (at most one bit set).
- `RspReady` input [1:0]: bit i = requester i consumes its response.
- `RspResult` output [31:0]: registered ALUResult, shared by both requesters, qualified by `RspValid`.
- `RspFlags` output [3:0]: registered ALUFlags {N,Z,C,V}, qualified by `RspValid`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `ReqValid` bit set, pick winner w; assert `ReqReady[w]` combinationally that cycle; capture w, `ReqControl`/`ReqSrcA`/`ReqSrcB` slices of w into operand registers; go to EXEC. No valid: stay IDLE, `ReqReady`=0.
- EXEC: operand registers drive the `alu` instance; capture `ALUResult` and `ALUFlags` into `RspResult`/`RspFlags`; go to RESP.
- RESP: `RspValid[w]`=1, result/flags held stable; when `RspReady[w]`=1, go to IDLE and record w as last-granted. `RspReady` of the other bit ignored.
- Winner selection, round-robin: single valid wins; both valid -> the requester not last-granted wins. Last-granted resets to 1, so requester 0 wins the first tie.
- Winner selection, fixed priority: requester 0 wins whenever `ReqValid[0]`=1; last-granted still tracked but unused.
- `ReqReady` never asserted outside IDLE; requests arriving during EXEC/RESP wait (requester holds valid and operands stable until ready).
- Requester dropping `ReqValid` before grant is legal; arbitration is re-evaluated every IDLE cycle.
- Flags are passed through unmodified from `alu`; the arbiter does no arithmetic.

## Timing
- Reset values: state IDLE, `ReqReady`=0, `RspValid`=0, `RspResult`=0, `RspFlags`=0, operand registers 0, last-granted=1.
- `reset` has priority over all transitions; asserting it in EXEC or RESP discards the operation, no response is ever issued for it, `RspValid` is 0 the cycle after reset is sampled.
- Latency: request accepted in cycle t (IDLE, `ReqReady[w]`=1) -> `RspValid[w]`=1 from cycle t+2.
- `RspReady[w]` already high when `RspValid` rises -> RESP lasts one cycle, IDLE at t+3, next accept at t+3 earliest; peak throughput one op per 3 cycles.
- `RspReady[w]` low -> RESP held indefinitely with result stable; no new accept.
- `ReqReady` is a combinational function of state, `ReqValid` and last-granted only (no path from `RspReady`).

## Test plan
- Reset then idle: hold `reset` 2 cycles, all `ReqValid`=0 -> `ReqReady`=0, `RspValid`=0, `RspResult`=0, `RspFlags`=0 for 5 cycles.
- Single SUB: req0 ADD->SUB 01, SrcA=1, SrcB=1 -> `ReqReady`=01 at t, `RspValid`=01 at t+2, `RspResult`=0, `RspFlags`=0110.
- Round-robin tie: both valid continuously, req0 ADD 1+0, req1 ORR 0|1, `RspReady`=11 -> grants alternate 0,1,0,1; results 1 and 1, each op 3 cycles apart.
- Fixed priority (`PRIORITY_MODE`=1): both valid continuously -> requester 0 granted every time, requester 1 never granted while `ReqValid[0]`=1.
- Response backpressure: req1 SUB SrcA=1, SrcB=2, `RspReady`=00 for 4 cycles -> `RspValid`=10 held, `RspResult`=FFFFFFFF, `RspFlags`=1000 stable, `ReqReady`=00 despite pending req0; release -> IDLE next cycle, req0 then granted.
- Reset mid-operation: assert `reset` in EXEC -> no `RspValid` ever for that op, state IDLE, last-granted=1, next tie granted to requester 0.
